// File: rtl/dual_writeback_queue_pkg.sv
// Shared definitions for the dual-result writeback queue: default widths,
// the queue entry record and the register-zero constant.
package dual_writeback_queue_pkg;

  localparam int unsigned XlenDef = 32;
  localparam int unsigned RaWDef  = 5;

  // Writes to this register are architecturally discarded.
  localparam int unsigned RegZero = 0;

  typedef struct packed {
    logic [RaWDef-1:0]  rd;
    logic [XlenDef-1:0] data;
  } wbq_entry_t;

endpackage

// File: rtl/dual_writeback_queue_pending_match.sv
// Pending-write lookup: ORs a comparison of the query register against every
// occupied queue entry. Register zero never reports pending.
module wbq_pending_match
  import dual_writeback_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned RA_W  = RaWDef
) (
  input  logic [DEPTH-1:0]           valid_i,
  input  logic [DEPTH-1:0][RA_W-1:0] rd_i,
  input  logic [RA_W-1:0]            query_i,
  output logic                       hit_o
);

  logic any_hit;

  always_comb begin
    any_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_i[i] && (rd_i[i] == query_i)) begin
        any_hit = 1'b1;
      end
    end
  end

  assign hit_o = any_hit & (query_i != RA_W'(RegZero));

endmodule

// File: rtl/dual_writeback_queue.sv
// In-order buffer for up to two ALU results per cycle, drained two at a time
// to the register file with show-ahead outputs and a pending-register query.
module dual_writeback_queue
  import dual_writeback_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = XlenDef,
  parameter int unsigned RA_W  = RaWDef
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_0,
  input  logic [XLEN-1:0]          in_data_0,
  input  logic [RA_W-1:0]          in_rd_0,
  input  logic                     in_valid_1,
  input  logic [XLEN-1:0]          in_data_1,
  input  logic [RA_W-1:0]          in_rd_1,
  output logic                     in_ready,
  input  logic                     wb_ready,
  output logic                     wb_en_0,
  output logic [RA_W-1:0]          wb_addr_0,
  output logic [XLEN-1:0]          wb_data_0,
  output logic                     wb_en_1,
  output logic [RA_W-1:0]          wb_addr_1,
  output logic [XLEN-1:0]          wb_data_1,
  input  logic [RA_W-1:0]          query_rd_a,
  output logic                     pending_a,
  input  logic [RA_W-1:0]          query_rd_b,
  output logic                     pending_b,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]            head_q, head_d, tail_q, tail_d;
  logic [PtrW-1:0]            head_p1, tail_p1, wr1_idx;
  logic [CntW-1:0]            count_q, count_d;
  logic                       overflow_q, overflow_d;
  logic [DEPTH-1:0]           vld_q, vld_d;
  logic [DEPTH-1:0][RA_W-1:0] rd_q, rd_d;
  logic [DEPTH-1:0][XLEN-1:0] data_q, data_d;

  logic       wr0, wr1, occ1, occ2, waw, pop0, pop1;
  logic [1:0] num_push, num_pop;

  assign head_p1 = head_q + PtrW'(1);
  assign tail_p1 = tail_q + PtrW'(1);

  // Two free slots are demanded so a full pair can always be accepted.
  assign in_ready = (count_q <= CntW'(DEPTH - 2));

  assign wr0 = in_ready & in_valid_0 & (in_rd_0 != RA_W'(RegZero));
  assign wr1 = in_ready & in_valid_1 & (in_rd_1 != RA_W'(RegZero));
  assign wr1_idx  = wr0 ? tail_p1 : tail_q;
  assign num_push = {1'b0, wr0} + {1'b0, wr1};

  assign occ1 = (count_q != '0);
  assign occ2 = (count_q >= CntW'(2));

  // Same destination at head and head+1: only the younger write survives.
  assign waw = occ2 & (rd_q[head_q] == rd_q[head_p1]);

  assign wb_en_0   = occ1 & ~waw;
  assign wb_addr_0 = rd_q[head_q];
  assign wb_data_0 = data_q[head_q];
  assign wb_en_1   = occ2;
  assign wb_addr_1 = rd_q[head_p1];
  assign wb_data_1 = data_q[head_p1];

  // A squashed head entry still pops, hence the raw occupancy terms.
  assign pop0    = wb_ready & occ1;
  assign pop1    = wb_ready & occ2;
  assign num_pop = {1'b0, pop0} + {1'b0, pop1};

  always_comb begin
    vld_d  = vld_q;
    rd_d   = rd_q;
    data_d = data_q;
    if (pop0) begin
      vld_d[head_q] = 1'b0;
    end
    if (pop1) begin
      vld_d[head_p1] = 1'b0;
    end
    if (wr0) begin
      vld_d[tail_q]  = 1'b1;
      rd_d[tail_q]   = in_rd_0;
      data_d[tail_q] = in_data_0;
    end
    if (wr1) begin
      vld_d[wr1_idx]  = 1'b1;
      rd_d[wr1_idx]   = in_rd_1;
      data_d[wr1_idx] = in_data_1;
    end
  end

  always_comb begin
    head_d     = head_q + PtrW'(num_pop);
    tail_d     = tail_q + PtrW'(num_push);
    count_d    = count_q + CntW'(num_push) - CntW'(num_pop);
    overflow_d = overflow_q | (~in_ready & (in_valid_0 | in_valid_1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      vld_q      <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      vld_q      <= vld_d;
    end
  end

  // Payload needs no reset; the valid bits and count gate every use of it.
  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end

  assign count    = count_q;
  assign overflow = overflow_q;

  wbq_pending_match #(
    .DEPTH (DEPTH),
    .RA_W  (RA_W)
  ) u_match_a (
    .valid_i (vld_q),
    .rd_i    (rd_q),
    .query_i (query_rd_a),
    .hit_o   (pending_a)
  );

  wbq_pending_match #(
    .DEPTH (DEPTH),
    .RA_W  (RA_W)
  ) u_match_b (
    .valid_i (vld_q),
    .rd_i    (rd_q),
    .query_i (query_rd_b),
    .hit_o   (pending_b)
  );

endmodule

// File: tb/tb_dual_writeback_queue.sv
// Bench for dual_writeback_queue: hand-written vector table, directed corner
// sequences and randomized traffic checked against a queue-based model.
module tb_dual_writeback_queue;
  import dual_writeback_queue_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_0, in_valid_1, wb_ready;
  logic [31:0] in_data_0, in_data_1, wb_data_0, wb_data_1;
  logic [4:0]  in_rd_0, in_rd_1, wb_addr_0, wb_addr_1, query_rd_a, query_rd_b;
  logic        in_ready, wb_en_0, wb_en_1, pending_a, pending_b, overflow;
  logic [3:0]  count;

  dual_writeback_queue #(
    .DEPTH (DEPTH),
    .XLEN  (32),
    .RA_W  (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_0 (in_valid_0),
    .in_data_0  (in_data_0),
    .in_rd_0    (in_rd_0),
    .in_valid_1 (in_valid_1),
    .in_data_1  (in_data_1),
    .in_rd_1    (in_rd_1),
    .in_ready   (in_ready),
    .wb_ready   (wb_ready),
    .wb_en_0    (wb_en_0),
    .wb_addr_0  (wb_addr_0),
    .wb_data_0  (wb_data_0),
    .wb_en_1    (wb_en_1),
    .wb_addr_1  (wb_addr_1),
    .wb_data_1  (wb_data_1),
    .query_rd_a (query_rd_a),
    .pending_a  (pending_a),
    .query_rd_b (query_rd_b),
    .pending_b  (pending_b),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v0;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic        wbr;
    logic [4:0]  qa;
    logic [4:0]  qb;
  } vin_t;

  typedef struct packed {
    logic [3:0]  cnt;
    logic        rdy;
    logic        e0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        e1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        pa;
    logic        pb;
    logic        ovf;
  } vout_t;

  typedef struct packed {
    vin_t  i;
    vout_t o;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  wbq_entry_t mq[$];
  logic       movf = 1'b0;

  function automatic vin_t mk_in(logic v0, logic [4:0] rd0, logic [31:0] d0, logic v1,
                                 logic [4:0] rd1, logic [31:0] d1, logic wbr,
                                 logic [4:0] qa, logic [4:0] qb);
    vin_t v;
    v = '{v0: v0, rd0: rd0, d0: d0, v1: v1, rd1: rd1, d1: d1, wbr: wbr, qa: qa, qb: qb};
    return v;
  endfunction

  function automatic vin_t idle(logic wbr, logic [4:0] qa, logic [4:0] qb);
    return mk_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, wbr, qa, qb);
  endfunction

  function automatic vout_t mk_out(logic [3:0] cnt, logic rdy, logic e0, logic [4:0] a0,
                                   logic [31:0] d0, logic e1, logic [4:0] a1,
                                   logic [31:0] d1, logic pa, logic pb, logic ovf);
    vout_t o;
    o = '{cnt: cnt, rdy: rdy, e0: e0, a0: a0, d0: d0, e1: e1, a1: a1, d1: d1,
          pa: pa, pb: pb, ovf: ovf};
    return o;
  endfunction

  function automatic vout_t empty_out(logic ovf);
    return mk_out(4'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, ovf);
  endfunction

  // Expected outputs straight from the queue contents, before the coming edge.
  function automatic vout_t model_out(vin_t v);
    vout_t o;
    int n;
    o = '0;
    n = mq.size();
    o.cnt = 4'(n);
    o.rdy = (n <= int'(DEPTH) - 2);
    o.ovf = movf;
    if (n >= 1) begin
      o.e0 = 1'b1;
      o.a0 = mq[0].rd;
      o.d0 = mq[0].data;
    end
    if (n >= 2) begin
      o.e1 = 1'b1;
      o.a1 = mq[1].rd;
      o.d1 = mq[1].data;
      if (mq[0].rd == mq[1].rd) o.e0 = 1'b0;
    end
    foreach (mq[k]) begin
      if (v.qa != 5'd0 && mq[k].rd == v.qa) o.pa = 1'b1;
      if (v.qb != 5'd0 && mq[k].rd == v.qb) o.pb = 1'b1;
    end
    return o;
  endfunction

  task automatic model_step(vin_t v);
    int  n;
    int  npop;
    bit  rdy;
    n    = mq.size();
    rdy  = (n <= int'(DEPTH) - 2);
    npop = v.wbr ? ((n >= 2) ? 2 : n) : 0;
    repeat (npop) void'(mq.pop_front());
    if (rdy) begin
      if (v.v0 && v.rd0 != 5'd0) mq.push_back('{rd: v.rd0, data: v.d0});
      if (v.v1 && v.rd1 != 5'd0) mq.push_back('{rd: v.rd1, data: v.d1});
    end else if (v.v0 || v.v1) begin
      movf = 1'b1;
    end
  endtask

  task automatic drive(vin_t v);
    in_valid_0 = v.v0;
    in_rd_0    = v.rd0;
    in_data_0  = v.d0;
    in_valid_1 = v.v1;
    in_rd_1    = v.rd1;
    in_data_1  = v.d1;
    wb_ready   = v.wbr;
    query_rd_a = v.qa;
    query_rd_b = v.qb;
  endtask

  task automatic check(string nm, vout_t exp);
    vout_t act;
    act = '{cnt: count, rdy: in_ready, e0: wb_en_0, a0: wb_addr_0, d0: wb_data_0,
            e1: wb_en_1, a1: wb_addr_1, d1: wb_data_1, pa: pending_a, pb: pending_b,
            ovf: overflow};
    // Port address/data are don't-care while its enable is expected low.
    if (!exp.e0) begin
      act.a0 = exp.a0;
      act.d0 = exp.d0;
    end
    if (!exp.e1) begin
      act.a1 = exp.a1;
      act.d1 = exp.d1;
    end
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(string nm, vin_t v, vout_t exp);
    drive(v);
    #1;
    check(nm, exp);
    model_step(v);
    @(negedge clk);
  endtask

  task automatic mstep(string nm, vin_t v);
    step(nm, v, model_out(v));
  endtask

  task automatic do_reset(string nm);
    rst = 1'b1;
    drive(idle(1'b0, 5'd0, 5'd0));
    mq.delete();
    movf = 1'b0;
    #1;
    check(nm, empty_out(1'b0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[19];

  initial begin
    tbl[0]  = '{i: idle(1, 0, 0), o: empty_out(0)};
    tbl[1]  = '{i: mk_in(1, 3, 'h11, 1, 4, 'h22, 1, 0, 0), o: empty_out(0)};
    tbl[2]  = '{i: idle(1, 0, 0), o: mk_out(2, 1, 1, 3, 'h11, 1, 4, 'h22, 0, 0, 0)};
    tbl[3]  = '{i: idle(1, 0, 0), o: empty_out(0)};
    tbl[4]  = '{i: mk_in(1, 0, 'h55, 1, 7, 'hAA, 0, 0, 0), o: empty_out(0)};
    tbl[5]  = '{i: idle(0, 7, 0), o: mk_out(1, 1, 1, 7, 'hAA, 0, 0, 0, 1, 0, 0)};
    tbl[6]  = '{i: idle(1, 7, 0), o: mk_out(1, 1, 1, 7, 'hAA, 0, 0, 0, 1, 0, 0)};
    tbl[7]  = '{i: idle(0, 7, 0), o: empty_out(0)};
    tbl[8]  = '{i: mk_in(1, 1, 'h101, 1, 2, 'h102, 0, 0, 0), o: empty_out(0)};
    tbl[9]  = '{i: mk_in(1, 3, 'h103, 1, 4, 'h104, 0, 0, 0),
                o: mk_out(2, 1, 1, 1, 'h101, 1, 2, 'h102, 0, 0, 0)};
    tbl[10] = '{i: mk_in(1, 5, 'h105, 1, 6, 'h106, 0, 0, 0),
                o: mk_out(4, 1, 1, 1, 'h101, 1, 2, 'h102, 0, 0, 0)};
    tbl[11] = '{i: mk_in(1, 8, 'h108, 1, 10, 'h10a, 0, 0, 0),
                o: mk_out(6, 1, 1, 1, 'h101, 1, 2, 'h102, 0, 0, 0)};
    tbl[12] = '{i: mk_in(1, 11, 'h10b, 1, 12, 'h10c, 0, 0, 0),
                o: mk_out(8, 0, 1, 1, 'h101, 1, 2, 'h102, 0, 0, 0)};
    tbl[13] = '{i: idle(0, 12, 10), o: mk_out(8, 0, 1, 1, 'h101, 1, 2, 'h102, 0, 1, 1)};
    tbl[14] = '{i: idle(1, 12, 10), o: mk_out(8, 0, 1, 1, 'h101, 1, 2, 'h102, 0, 1, 1)};
    tbl[15] = '{i: idle(1, 0, 10), o: mk_out(6, 1, 1, 3, 'h103, 1, 4, 'h104, 0, 1, 1)};
    tbl[16] = '{i: idle(1, 0, 0), o: mk_out(4, 1, 1, 5, 'h105, 1, 6, 'h106, 0, 0, 1)};
    tbl[17] = '{i: idle(1, 0, 10), o: mk_out(2, 1, 1, 8, 'h108, 1, 10, 'h10a, 0, 1, 1)};
    tbl[18] = '{i: idle(1, 0, 0), o: empty_out(1)};

    rst = 1'b1;
    drive(idle(1'b0, 5'd0, 5'd0));
    @(negedge clk);
    do_reset("reset");

    for (int k = 0; k < 19; k++) begin
      step($sformatf("tbl%0d", k), tbl[k].i, tbl[k].o);
    end

    // Same destination at head and head+1.
    do_reset("reset_waw");
    step("waw_push", mk_in(1, 5, 'h1, 1, 5, 'h2, 0, 5, 0), empty_out(0));
    step("waw_head", idle(1, 5, 0), mk_out(2, 1, 0, 5, 'h1, 1, 5, 'h2, 1, 0, 0));
    step("waw_popped", idle(1, 5, 0), empty_out(0));

    step("pend_push", mk_in(1, 9, 'h99, 0, 0, 0, 0, 0, 0), empty_out(0));
    step("pend_hold", idle(0, 9, 0), mk_out(1, 1, 1, 9, 'h99, 0, 0, 0, 1, 0, 0));
    step("pend_popping", idle(1, 9, 0), mk_out(1, 1, 1, 9, 'h99, 0, 0, 0, 1, 0, 0));
    step("pend_cleared", idle(1, 9, 0), empty_out(0));

    // Continuous push-2/pop-2 across several pointer wraps, then fill and drop.
    do_reset("reset_wrap");
    for (int k = 0; k < 20; k++) begin
      mstep($sformatf("wrap%0d", k),
            mk_in(1, 5'((2 * k) % 31 + 1), 32'(k * 16 + 1), 1, 5'((2 * k + 1) % 31 + 1),
                  32'(k * 16 + 2), 1, 5'((2 * k) % 31 + 1), 0));
    end
    for (int k = 0; k < 4; k++) begin
      mstep($sformatf("fill%0d", k),
            mk_in(1, 5'(k + 20), 32'(k + 'h200), 1, 5'(k + 24), 32'(k + 'h300), 0, 0, 0));
    end
    mstep("fill_ovf", idle(0, 0, 0));

    // Asynchronous reset away from the clock edge.
    #2;
    rst = 1'b1;
    mq.delete();
    movf = 1'b0;
    #1;
    check("rst_async", empty_out(0));
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 400; k++) begin
      vin_t v;
      v.v0  = ($urandom_range(0, 9) < 7);
      v.rd0 = 5'($urandom_range(0, 7));
      v.d0  = $urandom;
      v.v1  = ($urandom_range(0, 9) < 7);
      v.rd1 = 5'($urandom_range(0, 7));
      v.d1  = $urandom;
      v.wbr = ($urandom_range(0, 2) != 0);
      v.qa  = 5'($urandom_range(0, 7));
      v.qb  = 5'($urandom_range(0, 7));
      mstep($sformatf("rand%0d", k), v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
